// File: rtl/vga_reg_sequencer.sv
// ---------------------------------------------------------------------------
// vga_reg_sequencer
//
// Chooses which of the NUM_REGS 16-bit register values the VGA register
// viewer shows, and hands the viewer a copy of the register bus that only
// changes at frame starts so the digits never tear mid-frame.
//
// The selection is stepped by two debounced push buttons (next / prev) or,
// when auto_en is high, advanced automatically every DWELL_FRAMES frames.
// All selection and snapshot updates take effect together, one clk cycle
// after frame_tick.
//
// Ports
//   clk         100 MHz system clock
//   rst         asynchronous, active-low reset
//   vs          vertical sync (active-low pulse), asynchronous to clk
//   btn_next    raw, bouncing, active-high "next register" button
//   btn_prev    raw, bouncing, active-high "previous register" button
//   auto_en     1 = auto-cycle through registers, 0 = manual only
//   vals_in     live register bus, register k at [16k+15:16k]
//   sel         register index presented to the display (0..NUM_REGS-1)
//   vals_snap   frame-stable copy of vals_in
//   snap_valid  high once the first snapshot has been captured
//   frame_tick  one-cycle pulse per detected frame start (vs falling edge)
// ---------------------------------------------------------------------------
module vga_reg_sequencer #(
   parameter int NUM_REGS     = 7,
   parameter int DWELL_FRAMES = 60,
   parameter int DEB_CYCLES   = 1000000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         vs,
   input  logic         btn_next,
   input  logic         btn_prev,
   input  logic         auto_en,
   input  logic [111:0] vals_in,
   output logic [2:0]   sel,
   output logic [111:0] vals_snap,
   output logic         snap_valid,
   output logic         frame_tick
);

   // ------------------------------------------------------------------
   // Derived widths and constants
   // ------------------------------------------------------------------
   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
   localparam int DW_W  = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

   localparam logic [2:0]       SEL_MAX    = 3'(NUM_REGS - 1);
   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_FRAMES - 1);

   typedef enum logic [1:0] {
      DB_IDLE         = 2'd0,
      DB_PRESS_WAIT   = 2'd1,
      DB_HELD         = 2'd2,
      DB_RELEASE_WAIT = 2'd3
   } db_state_t;

   // ------------------------------------------------------------------
   // Frame start detection
   // vs is synchronised through two flops, then delayed once more so a
   // 1->0 transition of the synchronised level can be seen. The tick is
   // itself registered, so it rises on the third clk edge after vs is
   // first sampled low.
   // ------------------------------------------------------------------
   logic vs_meta_reg;
   logic vs_sync_reg;
   logic vs_prev_reg;
   logic frame_tick_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vs_meta_reg    <= 1'b0;
         vs_sync_reg    <= 1'b0;
         vs_prev_reg    <= 1'b0;
         frame_tick_reg <= 1'b0;
      end else begin
         vs_meta_reg    <= vs;
         vs_sync_reg    <= vs_meta_reg;
         vs_prev_reg    <= vs_sync_reg;
         // Sync registers reset low; vs idles high, so leaving reset only
         // produces a rising edge and never a spurious frame start.
         frame_tick_reg <= vs_prev_reg & ~vs_sync_reg;
      end
   end

   // ------------------------------------------------------------------
   // Button debouncers: index 0 = next, index 1 = prev.
   // Each button has its own synchroniser and four-state FSM. A press is
   // accepted after DEB_CYCLES stable-high cycles and yields exactly one
   // step pulse; a release must likewise be stable before a new press can
   // be recognised.
   // ------------------------------------------------------------------
   logic [1:0] btn_raw;
   logic [1:0] btn_step;

   assign btn_raw = {btn_prev, btn_next};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_deb
         logic             meta_reg;
         logic             sync_reg;
         db_state_t        state_reg;
         logic [CNT_W-1:0] cnt_reg;
         logic             step_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               meta_reg  <= 1'b0;
               sync_reg  <= 1'b0;
               state_reg <= DB_IDLE;
               cnt_reg   <= '0;
               step_reg  <= 1'b0;
            end else begin
               meta_reg <= btn_raw[gi];
               sync_reg <= meta_reg;
               step_reg <= 1'b0;

               case (state_reg)
                  DB_IDLE: begin
                     if (sync_reg) begin
                        state_reg <= DB_PRESS_WAIT;
                        cnt_reg   <= '0;
                     end
                  end

                  DB_PRESS_WAIT: begin
                     if (!sync_reg) begin
                        // Bounce: the press was not stable long enough.
                        state_reg <= DB_IDLE;
                     end else if (cnt_reg == DEB_LAST) begin
                        state_reg <= DB_HELD;
                        step_reg  <= 1'b1;
                     end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                     end
                  end

                  DB_HELD: begin
                     // Holding the button emits nothing further.
                     if (!sync_reg) begin
                        state_reg <= DB_RELEASE_WAIT;
                        cnt_reg   <= '0;
                     end
                  end

                  DB_RELEASE_WAIT: begin
                     if (sync_reg) begin
                        // Release bounce: still the same press.
                        state_reg <= DB_HELD;
                     end else if (cnt_reg == DEB_LAST) begin
                        state_reg <= DB_IDLE;
                     end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                     end
                  end

                  default: begin
                     state_reg <= DB_IDLE;
                     cnt_reg   <= '0;
                  end
               endcase
            end
         end

         assign btn_step[gi] = step_reg;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Pending steps, selection and dwell counter
   // ------------------------------------------------------------------
   logic              next_pend_reg;
   logic              next_pend_next;
   logic              prev_pend_reg;
   logic              prev_pend_next;
   logic [2:0]        sel_reg;
   logic [2:0]        sel_next;
   logic [2:0]        sel_inc;
   logic [2:0]        sel_dec;
   logic [DW_W-1:0]   dwell_reg;
   logic [DW_W-1:0]   dwell_next;
   logic [111:0]      vals_snap_reg;
   logic              snap_valid_reg;

   // Wrap-around neighbours of the current selection.
   assign sel_inc = (sel_reg == SEL_MAX) ? 3'd0    : sel_reg + 3'd1;
   assign sel_dec = (sel_reg == 3'd0)    ? SEL_MAX : sel_reg - 3'd1;

   always_comb begin
      // A frame consumes whatever was pending before it. A step pulse in
      // the frame_tick cycle is OR-ed in after the consume, so it survives
      // into the following frame.
      next_pend_next = (frame_tick_reg ? 1'b0 : next_pend_reg) | btn_step[0];
      prev_pend_next = (frame_tick_reg ? 1'b0 : prev_pend_reg) | btn_step[1];

      // Opposite steps within one frame cancel out.
      if (next_pend_next && prev_pend_next) begin
         next_pend_next = 1'b0;
         prev_pend_next = 1'b0;
      end
   end

   always_comb begin
      sel_next   = sel_reg;
      dwell_next = dwell_reg;

      if (frame_tick_reg) begin
         // At most one change per frame; a manual step wins over auto.
         if (next_pend_reg) begin
            sel_next   = sel_inc;
            dwell_next = '0;
         end else if (prev_pend_reg) begin
            sel_next   = sel_dec;
            dwell_next = '0;
         end else if (auto_en) begin
            if (dwell_reg == DWELL_LAST) begin
               sel_next   = sel_inc;
               dwell_next = '0;
            end else begin
               dwell_next = dwell_reg + DW_W'(1);
            end
         end
      end

      // Manual mode keeps the dwell parked at zero so that enabling auto
      // mode always starts a full dwell period.
      if (!auto_en) begin
         dwell_next = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         next_pend_reg  <= 1'b0;
         prev_pend_reg  <= 1'b0;
         sel_reg        <= 3'd0;
         dwell_reg      <= '0;
         vals_snap_reg  <= '0;
         snap_valid_reg <= 1'b0;
      end else begin
         next_pend_reg <= next_pend_next;
         prev_pend_reg <= prev_pend_next;
         sel_reg       <= sel_next;
         dwell_reg     <= dwell_next;
         // Snapshot shares the frame_tick cycle with the selection update,
         // so sel and vals_snap always change on the same clk edge.
         if (frame_tick_reg) begin
            vals_snap_reg  <= vals_in;
            snap_valid_reg <= 1'b1;
         end
      end
   end

   assign sel        = sel_reg;
   assign vals_snap  = vals_snap_reg;
   assign snap_valid = snap_valid_reg;
   assign frame_tick = frame_tick_reg;

endmodule
